// File: rtl/timer_ctl_pkg.sv
// Shared definitions for the timer controller master: the state encoding, the
// timer slave register map, the control register bit positions, and helpers
// that build one cycle of bus activity.
package timer_ctl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    WR_CTL,
    WAIT_IRQ,
    RD_STS,
    RD_WAIT,
    CLR_STS,
    STOP_CTL
  } state_t;

  // Register indices on the timer slave
  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;

  // Control register bit positions
  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  // Status register bit that flags a timeout
  localparam int STS_TO = 0;

  // One cycle worth of master-side bus outputs
  typedef struct packed {
    logic        chipselect;
    logic        write_n;
    logic [2:0]  address;
    logic [15:0] writedata;
  } bus_t;

  localparam bus_t BUS_IDLE = '{chipselect: 1'b0, write_n: 1'b1,
                                address: 3'd0, writedata: 16'h0000};

  function automatic bus_t bus_write(input logic [2:0] addr, input logic [15:0] data);
    bus_t b;
    b.chipselect = 1'b1;
    b.write_n    = 1'b0;
    b.address    = addr;
    b.writedata  = data;
    return b;
  endfunction

  function automatic bus_t bus_read(input logic [2:0] addr);
    bus_t b;
    b.chipselect = 1'b1;
    b.write_n    = 1'b1;
    b.address    = addr;
    b.writedata  = 16'h0000;
    return b;
  endfunction

  // Control word that arms the timer: interrupt enable + start, plus the
  // continuous bit when periodic mode is requested.
  function automatic logic [15:0] ctl_start_word(input logic cont);
    logic [15:0] w;
    w            = 16'h0000;
    w[CTL_ITO]   = 1'b1;
    w[CTL_CONT]  = cont;
    w[CTL_START] = 1'b1;
    return w;
  endfunction

  function automatic logic [15:0] ctl_stop_word();
    logic [15:0] w;
    w           = 16'h0000;
    w[CTL_STOP] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/timer_ctl_master_if.sv
// Bus between the timer controller master and the timer slave.
//   avm_address    3  register index
//   avm_chipselect 1  access strobe, one cycle per access
//   avm_write_n    1  0 = write, 1 = read (1 when idle)
//   avm_writedata 16  write data
//   avm_readdata  16  read data, driven by the slave
interface timer_ctl_master_if;
  import timer_ctl_pkg::*;

  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write_n,
    input  avm_writedata,
    output avm_readdata
  );

endinterface

// File: rtl/timer_ctl_master.sv
// Timer controller master: programs a timer slave over a simple register bus,
// services its timeout interrupt (status read, then status clear) and counts
// serviced timeouts. All bus outputs come straight from flops.
//
// Ports
//   clk, reset_n        clock, async active-low reset
//   cfg_start           program period/mode and start the timer (IDLE only)
//   cfg_stop            stop the timer
//   cfg_period[31:0]    timer period, must be non-zero
//   cfg_continuous      1 = periodic, 0 = one-shot
//   irq_in              level interrupt from the slave
//   avm                 master side of the slave bus
//   busy                controller not in IDLE
//   tick_pulse          one cycle per serviced timeout
//   tick_count[31:0]    serviced timeouts since last accepted start
//   cfg_err             one cycle pulse for a rejected start (period 0)
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for cfg_start
// WR_PL    | writing period[15:0] to PERIODL
// WR_PH    | writing period[31:16] to PERIODH
// WR_CTL   | writing control word that starts the timer
// WAIT_IRQ | timer running, waiting for irq_in or a stop request
// RD_STS   | status read cycle
// RD_WAIT  | waiting RD_LATENCY cycles for the read data
// CLR_STS  | clearing the timeout flag, counting the tick
// STOP_CTL | writing the stop bit to the control register
module timer_ctl_master
  import timer_ctl_pkg::*;
#(
  parameter int RD_LATENCY = 1  // legal range 1..4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cfg_start,
  input  logic                      cfg_stop,
  input  logic [31:0]               cfg_period,
  input  logic                      cfg_continuous,
  input  logic                      irq_in,
  timer_ctl_master_if.master        avm,
  output logic                      busy,
  output logic                      tick_pulse,
  output logic [31:0]               tick_count,
  output logic                      cfg_err
);

  // RD_WAIT down-counter starts at RD_LATENCY-1 and samples on terminal count
  localparam logic [1:0] RD_LOAD = 2'(RD_LATENCY - 1);

  state_t      state_q;
  state_t      state_d;
  bus_t        bus_q;
  bus_t        bus_d;
  logic [31:0] period_q;
  logic        cont_q;
  logic        stop_pending;
  logic [1:0]  rd_cnt;
  logic        sts_to;
  logic        start_ok;
  logic        unused_rd_bits;

  assign sts_to         = avm.avm_readdata[STS_TO];
  // The other status bits carry nothing this controller acts on.
  assign unused_rd_bits = ^avm.avm_readdata[15:1];
  assign start_ok       = cfg_start && (cfg_period != 32'd0);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_ok) state_d = WR_PL;
      WR_PL:    state_d = WR_PH;
      WR_PH:    state_d = WR_CTL;
      WR_CTL:   state_d = WAIT_IRQ;
      WAIT_IRQ: begin
        if (stop_pending || cfg_stop) state_d = STOP_CTL;
        else if (irq_in)              state_d = RD_STS;
      end
      RD_STS:   state_d = RD_WAIT;
      RD_WAIT:  if (rd_cnt == 2'd0) state_d = sts_to ? CLR_STS : WAIT_IRQ;
      CLR_STS: begin
        if (stop_pending) state_d = STOP_CTL;
        else if (cont_q)  state_d = WAIT_IRQ;
        else              state_d = IDLE;
      end
      STOP_CTL: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output logic: bus values for the state being entered, so the registered
  // bus lines up with the state register. WR_PL is only entered from IDLE on
  // an accepted start, before period_q is loaded, hence cfg_period there.
  always_comb begin
    bus_d = BUS_IDLE;
    case (state_d)
      WR_PL:    bus_d = bus_write(REG_PERIODL, cfg_period[15:0]);
      WR_PH:    bus_d = bus_write(REG_PERIODH, period_q[31:16]);
      WR_CTL:   bus_d = bus_write(REG_CONTROL, ctl_start_word(cont_q));
      RD_STS:   bus_d = bus_read(REG_STATUS);
      CLR_STS:  bus_d = bus_write(REG_STATUS, 16'h0000);
      STOP_CTL: bus_d = bus_write(REG_CONTROL, ctl_stop_word());
      default:  bus_d = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_q        <= BUS_IDLE;
      period_q     <= 32'd0;
      cont_q       <= 1'b0;
      tick_pulse   <= 1'b0;
      tick_count   <= 32'd0;
      cfg_err      <= 1'b0;
      stop_pending <= 1'b0;
      rd_cnt       <= 2'd0;
    end else begin
      bus_q      <= bus_d;
      tick_pulse <= (state_d == CLR_STS);
      cfg_err    <= (state_q == IDLE) && cfg_start && (cfg_period == 32'd0);

      if ((state_q == IDLE) && start_ok) begin
        period_q   <= cfg_period;
        cont_q     <= cfg_continuous;
        tick_count <= 32'd0;
      end else if (state_d == CLR_STS) begin
        tick_count <= tick_count + 32'd1;
      end

      if (state_q == RD_STS)
        rd_cnt <= RD_LOAD;
      else if ((state_q == RD_WAIT) && (rd_cnt != 2'd0))
        rd_cnt <= rd_cnt - 2'd1;

      // WAIT_IRQ acts on cfg_stop directly; elsewhere it is remembered.
      // STOP_CTL is already performing the stop, so its clear wins.
      if (state_q == IDLE) begin
        if (cfg_stop) stop_pending <= 1'b0;
      end else if (state_q == STOP_CTL) begin
        stop_pending <= 1'b0;
      end else if ((state_q != WAIT_IRQ) && cfg_stop) begin
        stop_pending <= 1'b1;
      end
    end
  end

  assign avm.avm_chipselect = bus_q.chipselect;
  assign avm.avm_write_n    = bus_q.write_n;
  assign avm.avm_address    = bus_q.address;
  assign avm.avm_writedata  = bus_q.writedata;
  assign busy               = (state_q != IDLE);

endmodule

// File: doc/timer_ctl_master.md
TIMER_CTL_MASTER -- requirements
Module: timer_ctl_master

Interface
REQ-001 Parameter: RD_LATENCY, default 1, slave read latency in clocks; legal range 1..4.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cfg_start  input  1  one-cycle request to program and start the timer.
REQ-005 cfg_stop  input  1  one-cycle request to stop the timer.
REQ-006 cfg_period  input  32  timer period in clocks; sampled on accepted cfg_start.
REQ-007 cfg_continuous  input  1  1 = periodic, 0 = one-shot; sampled with cfg_period.
REQ-008 irq_in  input  1  level interrupt from timer slave; same clock domain.
REQ-009 avm_address  output  3  register index on the slave port.
REQ-010 avm_chipselect  output  1  bus access strobe; one cycle per access.
REQ-011 avm_write_n  output  1  0 = write, 1 = read; 1 when idle.
REQ-012 avm_writedata  output  16  write data.
REQ-013 avm_readdata  input  16  read data, valid RD_LATENCY cycles after the read cycle.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 tick_pulse  output  1  one-cycle pulse per serviced timeout.
REQ-016 tick_count  output  32  serviced-timeout count.
REQ-017 cfg_err  output  1  one-cycle pulse when cfg_start is rejected.

Function
REQ-018 States: IDLE, WR_PL, WR_PH, WR_CTL, WAIT_IRQ, RD_STS, RD_WAIT, CLR_STS, STOP_CTL.
REQ-019 IDLE + cfg_start + cfg_period!=0 -> WR_PL; latch period and mode; clear tick_count to 0.
REQ-020 IDLE + cfg_start + cfg_period==0 -> cfg_err pulse next cycle; stay IDLE.
REQ-021 cfg_start outside IDLE is ignored; it causes no cfg_err.
REQ-022 WR_PL: chipselect=1, write_n=0, address=2, writedata=period[15:0]; -> WR_PH.
REQ-023 WR_PH: write, address=3, writedata=period[31:16]; -> WR_CTL.
REQ-024 WR_CTL: write, address=1, writedata=0x0007 if continuous, else 0x0005; -> WAIT_IRQ.
REQ-025 Write order is always PL, PH, CTL in consecutive cycles; start is written last.
REQ-026 WAIT_IRQ: chipselect=0; irq_in=1 -> RD_STS; stop_pending=1 or cfg_stop=1 -> STOP_CTL, with stop taking priority.
REQ-027 RD_STS: chipselect=1, write_n=1, address=0 for one cycle; -> RD_WAIT.
REQ-028 RD_WAIT: count RD_LATENCY cycles from RD_STS, then sample avm_readdata[0].
REQ-029 Sampled bit0=1 -> CLR_STS; sampled bit0=0 (spurious) -> WAIT_IRQ with no tick.
REQ-030 CLR_STS: write, address=0, writedata=0x0000; assert tick_pulse; tick_count+1, wrapping 0xFFFFFFFF -> 0.
REQ-031 After CLR_STS: continuous and no stop pending -> WAIT_IRQ; one-shot -> IDLE; stop pending -> STOP_CTL.
REQ-032 STOP_CTL: write, address=1, writedata=0x0008; clear stop_pending; -> IDLE.
REQ-033 cfg_stop in any state other than IDLE or WAIT_IRQ sets stop_pending.
REQ-034 cfg_stop in IDLE is ignored and clears stop_pending.
REQ-035 In every non-access cycle: chipselect=0, write_n=1, address=0, writedata=0.
REQ-036 Bus outputs are registered; no combinational path from inputs to avm_* outputs.

Reset
REQ-037 Reset SHALL force: state=IDLE, chipselect=0, write_n=1, address=0, writedata=0, busy=0, tick_pulse=0, tick_count=0, cfg_err=0, stop_pending=0.
REQ-038 Reset mid-transaction SHALL abandon the access immediately; there is no bus cleanup on exit from reset.

Structure
REQ-039 Shared package timer_ctl_pkg SHALL hold the state enum, the register indices (STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3), and the control bits (ITO=0, CONT=1, START=2, STOP=3).
REQ-040 The block is a single module with no sub-modules; the RD_WAIT counter is inline.

Verification
REQ-041 cfg_period=0x0007A120, continuous: bus writes (2,0xA120),(3,0x0007),(1,0x0007) in three consecutive cycles; busy=1.
REQ-042 Slave model with period 100, continuous: ten irqs -> tick_count=10; exactly one status read and one clear write per irq; no double count.
REQ-043 One-shot, period 50: one irq -> one tick_pulse, then IDLE, busy=0; no further bus traffic.
REQ-044 cfg_stop asserted during WR_PH -> CTL start write still issues, then (1,0x0008) at the first WAIT_IRQ cycle, then IDLE.
REQ-045 Forced spurious read (bit0=0) with RD_LATENCY=3 -> no tick, return to WAIT_IRQ; cfg_period=0 -> cfg_err pulse, no bus access.
REQ-046 reset_n low during RD_WAIT -> all outputs at reset values on the same edge; a new cfg_start reprograms cleanly.
